uart_tx_mmio: RTL
=================

Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter attached directly downstream of the CPU data bus (Dw* signals). CPU stores push bytes into a transmit FIFO. A serialiser FSM shifts them out as 8N1 frames on oTX. Status and divisor registers are readable on the same bus; read data is combinational so single-cycle cores see it in the same cycle.

Parameters:
BASE_ADDR, 32'hFF200160, word-aligned base; block decodes BASE_ADDR+0/+4/+8 only
DEPTH, 16, FIFO entries; power of two, 2..256
DIV_RESET, 16'd433, reset value of DIVISOR register (50 MHz / 115200 − 1)

Ports:
iCLK  in  1  system clock
iRST  in  1  reset, synchronous, active-high
iReadEnable  in  1  bus read strobe (DwReadEnable)
iWriteEnable  in  1  bus write strobe (DwWriteEnable)
iByteEnable  in  4  bus byte lanes (DwByteEnable)
iAddress  in  32  bus address (DwAddress)
iWriteData  in  32  bus write data (DwWriteData)
oReadData  out  32  read data; 32'h0 when not selected or iReadEnable=0
oTX  out  1  serial line, idle high
oIRQ  out  1  high while FIFO empty and serialiser idle (transmit complete)

Behaviour:
- Clocking: single clock iCLK. Reset iRST is synchronous and active-high. All state changes on the rising edge of iCLK.
- Reset values: oTX=1, oIRQ=1 (derived), FIFO empty (count=0), overflow=0, DIVISOR=DIV_RESET, FSM=IDLE. oReadData=0 unless a read is in progress.
- Address decode: hit when iAddress[31:4] equals BASE_ADDR[31:4] and iAddress[3:2] is in {0,1,2}. Offset 12 and bits[1:0] are ignored (the access is treated as no hit / word select only).
- TXDATA (+0), write only: on iWriteEnable and iByteEnable[0]=1, push iWriteData[7:0]. Reads return 0.
- STATUS (+4), read: bit0 full, bit1 empty, bit2 busy (FSM≠IDLE), bit3 overflow, bits[16:8] count (0..DEPTH). Other bits are 0. A write with iWriteData[3]=1 and iByteEnable[0]=1 clears overflow.
- DIVISOR (+8), read/write: bits[15:0] hold the value. Written per byte lane (lanes 0,1). Upper bits read 0.
- Push rule: a push is accepted if count<DEPTH, or if a pop occurs in the same cycle. Otherwise the byte is dropped and overflow is set (sticky).
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Count is a separate register, log2(DEPTH)+1 bits.
- Bit period is DIVISOR+1 cycles. A down-counter reloads from DIVISOR at each bit start. A DIVISOR write while busy takes effect at the next bit boundary, never mid-bit.
- FSM states:
  - IDLE: oTX=1. If FIFO is non-empty, pop into the shift register and go to START on the same edge.
  - START: oTX=0 for one bit period, then go to DATA with bit index 0.
  - DATA: oTX=shift[0], LSB first. After each period, shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: oTX=1 for one bit period. Then, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Frame length is exactly 10×(DIVISOR+1) cycles. The first START begins on the cycle after the edge that popped the byte.
- oIRQ = empty & (FSM==IDLE), registered.
- Reset asserted mid-frame: FSM→IDLE and oTX=1 on the next edge. The FIFO is flushed and the frame is truncated with no completion.
- Reads have no side effects. A read and a write to different offsets in the same cycle are both serviced.

Test Plan:
- Reset then read +4 → oReadData=32'h0000_0002 (empty); read +8 → 433; oTX=1; oIRQ=1.
- DIVISOR=3, write 8'hA5 to +0 → oTX low 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, high 4 cycles; busy=1 during the frame, oIRQ returns to 1 after STOP.
- DIVISOR=0, push 8'h55 and 8'h0F back-to-back → 20 contiguous cycles of frame data with no idle between the STOP of byte 1 and the START of byte 2.
- DIVISOR=100, push 17 bytes with DEPTH=16 while the first frame is in progress → the first pop empties one slot, all 17 are accepted, overflow=0. Push 2 more → count=16, full=1, overflow=1, extra byte never transmitted. Write +4 data 8 → overflow=0.
- Write DIVISOR=9 mid-bit while DIVISOR=3 → current bit finishes at 4 cycles, next bit lasts 10.
- Assert iRST for one cycle mid-DATA with 3 bytes queued → next cycle oTX=1, count=0, busy=0, DIVISOR=433.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with byte FIFO
//
// Purpose:
//   CPU stores to TXDATA push bytes into a DEPTH-entry FIFO. A serialiser
//   pops them and shifts out 8N1 frames on oTX, LSB first. STATUS and
//   DIVISOR are readable on the same bus. Read data is combinational so a
//   single-cycle core sees it in the same cycle.
//
// Register map (word offsets from BASE_ADDR, address bits [1:0] ignored):
//   +0 TXDATA  W   [7:0] byte to push (byte lane 0)
//   +4 STATUS  R   [0] full [1] empty [2] busy [3] overflow [16:8] count
//              W   data[3]=1 with lane 0 clears overflow
//   +8 DIVISOR R/W [15:0] bit period minus one, lanes 0 and 1
//
// Ports:
//   iCLK          system clock
//   iRST          synchronous active-high reset
//   iReadEnable   bus read strobe
//   iWriteEnable  bus write strobe
//   iByteEnable   bus byte lanes [3:0]
//   iAddress      bus address [31:0]
//   iWriteData    bus write data [31:0]
//   oReadData     read data, zero when not selected or not reading
//   oTX           serial line, idles high
//   oIRQ          high while FIFO empty and serialiser idle

module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'hFF200160,
  parameter int          DEPTH     = 16,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReadEnable,
  input  logic        iWriteEnable,
  input  logic [3:0]  iByteEnable,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic [31:0] oReadData,
  output logic        oTX,
  output logic        oIRQ
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t state, state_n;

  logic [15:0]   divisor;
  logic [15:0]   bit_cnt, bit_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx, tx_n;
  logic          irq, irq_n;

  logic [7:0]    fifo_mem [0:DEPTH-1];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic          overflow;

  logic [1:0]    offset;
  logic          hit, sel_txdata, sel_status, sel_div;
  logic          push_req, push_ok, pop;
  logic          fifo_empty, fifo_full, bit_done;
  logic [31:0]   status_word;

  // Address bits [1:0], the upper data half and the upper lanes carry no
  // information for this block.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{iAddress[1:0], iWriteData[31:16], iByteEnable[3:2]};

  // Offset 12 falls inside the 16-byte window but is not a register.
  assign offset     = iAddress[3:2];
  assign hit        = (iAddress[31:4] == BASE_ADDR[31:4]) && (offset != 2'd3);
  assign sel_txdata = hit && (offset == 2'd0);
  assign sel_status = hit && (offset == 2'd1);
  assign sel_div    = hit && (offset == 2'd2);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign bit_done   = (bit_cnt == 16'd0);

  // A full FIFO still accepts a byte when the serialiser frees a slot on
  // the same edge.
  assign push_req = iWriteEnable && sel_txdata && iByteEnable[0];
  assign push_ok  = push_req && (!fifo_full || pop);

  // Serialiser next-state logic. The bit counter reloads from DIVISOR only
  // at a bit start, so a DIVISOR write never stretches or cuts a bit that
  // is already under way.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_n   = fifo_mem[rd_ptr];
          bit_cnt_n = divisor;
          state_n   = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          bit_idx_n = 3'd0;
          bit_cnt_n = divisor;
          state_n   = S_DATA;
        end else begin
          bit_cnt_n = bit_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          shift_n   = {1'b0, shift[7:1]};
          bit_cnt_n = divisor;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          bit_cnt_n = bit_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            // Back-to-back frame: no idle gap after the stop bit.
            pop       = 1'b1;
            shift_n   = fifo_mem[rd_ptr];
            bit_cnt_n = divisor;
            state_n   = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt - 16'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_comb begin
    count_n = count;
    case ({push_ok, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  // Outputs are registered from next-state values so they change on the
  // same edge as the state they describe, without decode glitches.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
    irq_n = (count_n == '0) && (state_n == S_IDLE);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= S_IDLE;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx      <= 1'b1;
      irq     <= 1'b1;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
      irq     <= irq_n;
    end
  end

  // FIFO storage needs no reset; the pointers and count define validity.
  always_ff @(posedge iCLK) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= iWriteData[7:0];
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_n;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      overflow <= 1'b0;
    end else if (push_req && !push_ok) begin
      overflow <= 1'b1;
    end else if (iWriteEnable && sel_status && iByteEnable[0] && iWriteData[3]) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      divisor <= DIV_RESET;
    end else if (iWriteEnable && sel_div) begin
      if (iByteEnable[0]) begin
        divisor[7:0] <= iWriteData[7:0];
      end
      if (iByteEnable[1]) begin
        divisor[15:8] <= iWriteData[15:8];
      end
    end
  end

  always_comb begin
    status_word         = 32'h0;
    status_word[0]      = fifo_full;
    status_word[1]      = fifo_empty;
    status_word[2]      = (state != S_IDLE);
    status_word[3]      = overflow;
    status_word[8 +: CW] = count;
  end

  always_comb begin
    oReadData = 32'h0;
    if (iReadEnable && hit) begin
      case (offset)
        2'd1:    oReadData = status_word;
        2'd2:    oReadData = {16'h0, divisor};
        default: oReadData = 32'h0;
      endcase
    end
  end

  assign oTX  = tx;
  assign oIRQ = irq;

endmodule
